// File: rtl/manchester_encoder.sv
// Frames bytes behind preamble 0xAAD5 and sends them MSB-first as Manchester half-bits (d -> ~d,d).
// First half-bit appears one cycle after buf_full sets; s_axis_tready is low whenever the single holding byte is full.
module manchester_encoder #(
    parameter int FRAME_SIZE       = 4,
    parameter int CLKS_PER_HALFBIT = 4,
    parameter int GAP_HALFBITS     = 8
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       tx_out,
    output logic       tx_active,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [7:0]  DIV_LAST = 8'(CLKS_PER_HALFBIT - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_HALFBITS - 1);
    localparam logic [3:0]  BYTES    = 4'(FRAME_SIZE);
    localparam logic [15:0] PREAMBLE = 16'hAAD5;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_GAP} state_t;

    state_t      r_state,      w_state_nxt;
    logic [15:0] r_shift,      w_shift_nxt;
    logic [3:0]  r_bit_cnt,    w_bit_cnt_nxt;
    logic        r_half,       w_half_nxt;
    logic [3:0]  r_byte_cnt,   w_byte_cnt_nxt;
    logic [7:0]  r_div_cnt,    w_div_cnt_nxt;
    logic [7:0]  r_gap_cnt,    w_gap_cnt_nxt;
    logic        r_tx_out,     w_tx_out_nxt;
    logic        r_tx_active,  w_tx_active_nxt;
    logic        r_frame_done, w_frame_done_nxt;
    logic        r_underrun,   w_underrun_nxt;
    logic        r_buf_full;
    logic [7:0]  r_buf_dat;
    logic        w_buf_take;
    logic        w_hb_end;
    logic [3:0]  w_byte_cnt_inc;

    assign s_axis_tready  = ~r_buf_full;
    assign tx_out         = r_tx_out;
    assign tx_active      = r_tx_active;
    assign frame_done     = r_frame_done;
    assign underrun       = r_underrun;
    assign w_hb_end       = (r_div_cnt == DIV_LAST);
    assign w_byte_cnt_inc = r_byte_cnt + 4'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_half_nxt       = r_half;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_tx_out_nxt     = r_tx_out;
        w_tx_active_nxt  = r_tx_active;
        w_frame_done_nxt = 1'b0;
        w_underrun_nxt   = 1'b0;
        w_buf_take       = 1'b0;
        w_div_cnt_nxt    = (r_state == S_IDLE || w_hb_end) ? 8'd0 : r_div_cnt + 8'd1;

        case (r_state)
            S_IDLE: begin
                if (r_buf_full) begin
                    w_state_nxt     = S_PREAMBLE;
                    w_shift_nxt     = PREAMBLE;
                    w_bit_cnt_nxt   = 4'd15;
                    w_half_nxt      = 1'b0;
                    w_byte_cnt_nxt  = 4'd0;
                    w_tx_out_nxt    = ~PREAMBLE[15];
                    w_tx_active_nxt = 1'b1;
                end
            end
            S_PREAMBLE, S_DATA: begin
                if (w_hb_end) begin
                    if (!r_half) begin
                        w_half_nxt   = 1'b1;
                        w_tx_out_nxt = r_shift[15];
                    end else if (r_bit_cnt != 4'd0) begin
                        w_half_nxt    = 1'b0;
                        w_shift_nxt   = {r_shift[14:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - 4'd1;
                        w_tx_out_nxt  = ~r_shift[14];
                    end else begin
                        // Unit finished: either chain the held byte in with no dead cycle, or close the frame.
                        if (r_state == S_DATA) begin
                            w_byte_cnt_nxt = w_byte_cnt_inc;
                        end
                        if (r_state == S_DATA && w_byte_cnt_inc == BYTES) begin
                            w_frame_done_nxt = 1'b1;
                        end else if (!r_buf_full) begin
                            w_underrun_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = S_DATA;
                            w_shift_nxt   = {r_buf_dat, 8'h00};
                            w_bit_cnt_nxt = 4'd7;
                            w_half_nxt    = 1'b0;
                            w_tx_out_nxt  = ~r_buf_dat[7];
                            w_buf_take    = 1'b1;
                        end
                        if (w_frame_done_nxt || w_underrun_nxt) begin
                            w_state_nxt     = S_GAP;
                            w_tx_out_nxt    = 1'b0;
                            w_tx_active_nxt = 1'b0;
                            w_gap_cnt_nxt   = 8'd0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_hb_end) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_shift      <= 16'd0;
            r_bit_cnt    <= 4'd0;
            r_half       <= 1'b0;
            r_byte_cnt   <= 4'd0;
            r_div_cnt    <= 8'd0;
            r_gap_cnt    <= 8'd0;
            r_tx_out     <= 1'b0;
            r_tx_active  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_half       <= w_half_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_tx_out     <= w_tx_out_nxt;
            r_tx_active  <= w_tx_active_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    // Take and handshake never coincide: tready is low whenever a take is possible.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_buf_full <= 1'b0;
            r_buf_dat  <= 8'd0;
        end else if (w_buf_take) begin
            r_buf_full <= 1'b0;
        end else if (s_axis_tvalid && !r_buf_full) begin
            r_buf_full <= 1'b1;
            r_buf_dat  <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_manchester_encoder.sv
// Scoreboard bench: expected per-cycle line levels are queued as bytes are accepted and checked on every negedge.
module tb_manchester_encoder;

    localparam int FS  = 4;
    localparam int CPH = 4;
    localparam int GAP = 8;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_axis_tdata = 8'd0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       tx_out;
    logic       tx_active;
    logic       frame_done;
    logic       underrun;

    manchester_encoder #(
        .FRAME_SIZE      (FS),
        .CLKS_PER_HALFBIT(CPH),
        .GAP_HALFBITS    (GAP)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .tx_out       (tx_out),
        .tx_active    (tx_active),
        .frame_done   (frame_done),
        .underrun     (underrun)
    );

    always #5 aclk = ~aclk;

    int   n_chk = 0;
    int   n_pass = 0;
    logic exp_q[$];
    int   len_q[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   lat_arm = 1'b0;
    logic prev_active = 1'b0;
    bit   have_fall = 1'b0;
    int   act_cnt = 0;
    int   idle_cnt = 0;
    int   rdy_pre = 0;
    int   fd_cnt = 0;
    int   ur_cnt = 0;
    int   fd0, ur0;
    logic [7:0] cnt_byte = 8'h40;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push_unit(input logic [15:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            repeat (CPH) exp_q.push_back(~v[i]);
            repeat (CPH) exp_q.push_back(v[i]);
        end
    endtask

    task automatic start_frame(input int nbytes);
        push_unit(16'hAAD5, 16);
        len_q.push_back((16 + 8 * nbytes) * 2 * CPH);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        while (!s_axis_tready && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axis_tready) begin
            chk("accept_timeout", 0, 1);
            s_axis_tvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        push_unit({8'h00, b}, 8);
        @(negedge aclk);
        acc_cyc       = cyc;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge aclk);
        while ((exp_q.size() != 0 || tx_active) && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge aclk);
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_active = 1'b0;
            have_fall   = 1'b0;
            act_cnt     = 0;
            idle_cnt    = 0;
        end else begin
            if (tx_active) begin
                if (!prev_active) begin
                    if (have_fall) chk("gap_min", 32'(idle_cnt >= GAP * CPH + 1), 1);
                    if (lat_arm) begin
                        chk("start_latency", cyc - acc_cyc, 1);
                        lat_arm = 1'b0;
                    end
                    act_cnt = 0;
                    rdy_pre = 0;
                end
                act_cnt++;
                if (act_cnt <= 32 * CPH && s_axis_tready) rdy_pre++;
                if (exp_q.size() == 0) chk("extra_halfbit", 1, 0);
                else chk("tx_out", tx_out, exp_q.pop_front());
            end else begin
                if (prev_active) begin
                    if (len_q.size() == 0) chk("unexpected_frame", 1, 0);
                    else chk("frame_len", act_cnt, len_q.pop_front());
                    chk("rdy_in_pre", rdy_pre, 0);
                    have_fall = 1'b1;
                    idle_cnt  = 0;
                end
                idle_cnt++;
                chk("idle_line", tx_out, 0);
            end
            if (frame_done || underrun) begin
                chk("pulse_on_fall", 32'(prev_active && !tx_active), 1);
                chk("pulse_excl", 32'(frame_done && underrun), 0);
            end
            if (frame_done) fd_cnt++;
            if (underrun) ur_cnt++;
            prev_active = tx_active;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_tready", s_axis_tready, 1);
        chk("rst_tx_out", tx_out, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // Single frame, latency and preamble start
        fd0 = fd_cnt; ur0 = ur_cnt;
        lat_arm = 1'b1;
        start_frame(4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        drain();
        chk("s1_frame_done", fd_cnt - fd0, 1);
        chk("s1_underrun", ur_cnt - ur0, 0);

        // Byte boundary patterns
        fd0 = fd_cnt; ur0 = ur_cnt;
        start_frame(4);
        send_byte(8'hF0); send_byte(8'hA5); send_byte(8'h00); send_byte(8'hFF);
        drain();
        chk("s2_frame_done", fd_cnt - fd0, 1);
        chk("s2_underrun", ur_cnt - ur0, 0);

        // Underrun after two bytes, then a full frame
        fd0 = fd_cnt; ur0 = ur_cnt;
        start_frame(2);
        send_byte(8'h5A); send_byte(8'hC3);
        drain();
        chk("s3_underrun", ur_cnt - ur0, 1);
        chk("s3_frame_done", fd_cnt - fd0, 0);
        fd0 = fd_cnt; ur0 = ur_cnt;
        start_frame(4);
        send_byte(8'h81); send_byte(8'h7E); send_byte(8'h3C); send_byte(8'hE7);
        drain();
        chk("s3b_frame_done", fd_cnt - fd0, 1);
        chk("s3b_underrun", ur_cnt - ur0, 0);

        // Continuous source with an incrementing count across three frames
        fd0 = fd_cnt; ur0 = ur_cnt;
        for (int f = 0; f < 3; f++) begin
            start_frame(4);
            for (int b = 0; b < FS; b++) begin
                send_byte(cnt_byte);
                cnt_byte = cnt_byte + 8'd1;
            end
        end
        drain();
        chk("s4_frame_done", fd_cnt - fd0, 3);
        chk("s4_underrun", ur_cnt - ur0, 0);

        // Asynchronous reset halfway through byte 2
        start_frame(4);
        send_byte(8'h11); send_byte(8'h22);
        repeat (96) @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tready", s_axis_tready, 1);
        chk("mid_rst_tx_out", tx_out, 0);
        chk("mid_rst_tx_active", tx_active, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_underrun", underrun, 0);
        exp_q.delete();
        len_q.delete();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        fd0 = fd_cnt; ur0 = ur_cnt;
        start_frame(4);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        drain();
        chk("s5_frame_done", fd_cnt - fd0, 1);
        chk("s5_underrun", ur_cnt - ur0, 0);
        chk("s5_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/manchester_encoder.md
# manchester_encoder

Manchester transmitter for the XAPP523-style serial link. It accepts payload bytes over an AXI-Stream-style byte interface, frames them behind the 16-bit preamble 0xAAD5, and serializes each frame MSB-first as Manchester half-bits on a single output line. It sits at the transmit end of the link whose receiver decodes with the same bit convention, preamble and fixed frame length.

## Interface
- FRAME_SIZE, 4, payload bytes per frame (1..15).
- CLKS_PER_HALFBIT, 4, aclk cycles per Manchester half-bit (1..256).
- GAP_HALFBITS, 8, idle half-bits forced between frames (1..255).
- aclk  in  1  single clock; all logic on rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted on the edge where tvalid && tready.
- tx_out  out  1  Manchester line; idle level 0.
- tx_active  out  1  high while preamble or payload half-bits are on tx_out.
- frame_done  out  1  one-cycle pulse at the end of a complete frame.
- underrun  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- Bit encoding: data bit d is sent as half-bit ~d, then half-bit d. So 1 is sent as 0→1 and 0 as 1→0. The decoded value equals the second half-bit.
- Frame layout: preamble 0xAAD5 MSB-first (16 bits, 32 half-bits), then FRAME_SIZE bytes, each MSB-first. No trailer.
- Input buffer: a one-entry holding register.
  - s_axis_tready = ~buf_full.
  - Handshake sets buf_full. Transfer of the held byte to the bit shifter clears it.
  - Simultaneous transfer and handshake is impossible because tready is low while full.
- FSM states: IDLE, PREAMBLE, DATA, GAP.
- IDLE: tx_out=0, tx_active=0. When buf_full=1, go to PREAMBLE and load the shifter with 0xAAD5. byte_cnt=0.
- PREAMBLE: shift out 32 half-bits. At the end of the last half-bit, the buffer byte moves into the shifter, buf_full clears and the FSM goes to DATA. buf_full is guaranteed set here because it triggered the frame.
- DATA: shift out 16 half-bits per byte. At the end of each byte, byte_cnt increments (4-bit, no wrap, since FRAME_SIZE≤15). Then:
  - If byte_cnt reaches FRAME_SIZE: pulse frame_done and go to GAP.
  - Else, if buf_full: load the next byte and stay in DATA.
  - Else: pulse underrun and go to GAP. The frame is truncated and is not padded.
- GAP: tx_out=0, tx_active=0 for GAP_HALFBITS half-bits, then IDLE. The buffer may accept a byte during GAP, but the next frame starts only from IDLE.
- Half-bit timing: div_cnt counts 0..CLKS_PER_HALFBIT-1 while in PREAMBLE, DATA or GAP. A half-bit boundary is div_cnt==CLKS_PER_HALFBIT-1. div_cnt is held at 0 in IDLE.
- Reset (any time, including mid-frame):
  - state=IDLE, tx_out=0, tx_active=0, frame_done=0, underrun=0, buf_full=0 (so s_axis_tready=1 after release).
  - Counters and shifter clear; any partial frame is abandoned.

## Timing
- All outputs are registered except s_axis_tready, which is decoded from the buf_full flop.
- Start latency: handshake at edge E0 sets buf_full. IDLE samples it, and the first preamble half-bit (0) appears on tx_out and tx_active rises after edge E0+1.
- Every half-bit is held exactly CLKS_PER_HALFBIT cycles. There is no dead cycle between the preamble and data, or between bytes.
- Frame duration on the line is (16+8·FRAME_SIZE)·2·CLKS_PER_HALFBIT cycles.
- The byte-load edge coincides with the last half-bit boundary of the previous unit. tready rises the cycle after that edge.
- To sustain back-to-back bytes, the source must present the next byte within 16·CLKS_PER_HALFBIT−1 cycles of tready rising.
- frame_done and underrun assert in the same cycle that tx_active falls, and are mutually exclusive.
- Minimum frame-to-frame spacing is GAP_HALFBITS·CLKS_PER_HALFBIT + 1 cycles of idle line.

## Test plan
- Single frame: FRAME_SIZE=4, CLKS_PER_HALFBIT=1, bytes 0x01,0x02,0x03,0x04 offered back-to-back.
  - tx_out begins 0,1,1,0,0,1,1,0 (preamble bits 1,0,1,0).
  - Total active half-bits = 96; frame_done pulses once; underrun stays 0.
  - Loopback through the team's Manchester receiver yields 0x01..0x04.
- Byte boundary: CLKS_PER_HALFBIT=4, byte 0xF0.
  - Payload half-bits are 01010101 10101010, each 4 cycles wide.
  - No glitch or extra cycle at the preamble→data or byte→byte boundary.
- Underrun: FRAME_SIZE=4; send 2 bytes, then hold tvalid low.
  - underrun pulses at the end of byte 2; tx_active falls; tx_out=0.
  - After the gap, a new 4-byte burst produces a full frame starting with a new preamble.
- Backpressure: hold tvalid high with an incrementing byte counter.
  - tready is low throughout the preamble; exactly one byte is accepted per byte period.
  - No byte is lost or duplicated across 3 consecutive frames.
  - Idle between frames is ≥ GAP_HALFBITS·CLKS_PER_HALFBIT+1 cycles.
- Reset mid-frame: assert aresetn low asynchronously halfway through byte 2 (not on a clock edge).
  - All outputs return to their reset values immediately: tready=1, tx_out=0.
  - After release, a fresh 4-byte burst produces a complete, correct frame.
